// File: rtl/pp_pipeline_accel_div_seq_21s_9s_12u_if.sv
// Operand/result handshake bundle for the sequential 21s/9s->12u divider.
// master drives operands and out_ready; slave is the divider side.
interface pp_pipeline_accel_div_seq_21s_9s_12u_if #(
  parameter int DIVIDEND_W = 21,
  parameter int DIVISOR_W  = 9,
  parameter int QUOTIENT_W = 12
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DIVIDEND_W-1:0] dividend;
  logic [DIVISOR_W-1:0]  divisor;
  logic                  out_valid;
  logic                  out_ready;
  logic [QUOTIENT_W-1:0] quotient;
  logic [DIVISOR_W-1:0]  remainder;
  logic                  sat;
  logic                  dz;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, sat, dz
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, sat, dz
  );
endinterface

// File: rtl/pp_pipeline_accel_div_seq_21s_9s_12u.sv
// Restoring radix-2 divider recovering the 12-bit unsigned operand of a 12u x 9s product.
// Result valid 22 enabled cycles after acceptance; one op in flight, result held until out_ready.
module pp_pipeline_accel_div_seq_21s_9s_12u #(
  parameter int DIVIDEND_W = 21,
  parameter int DIVISOR_W  = 9,
  parameter int QUOTIENT_W = 12
) (
  input  logic clk,
  input  logic reset_n,
  input  logic ce,
  pp_pipeline_accel_div_seq_21s_9s_12u_if.slave bus
);

  localparam int CNT_W = $clog2(DIVIDEND_W);
  localparam logic [DIVIDEND_W-1:0] QMAX =
    {{(DIVIDEND_W-QUOTIENT_W){1'b0}}, {QUOTIENT_W{1'b1}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DIVIDEND_W-1:0] dvd_q, dvd_d;
  logic [DIVIDEND_W-1:0] quo_q, quo_d;
  logic [DIVISOR_W-1:0]  dsr_q, dsr_d;
  logic [DIVISOR_W:0]    rem_q, rem_d;
  logic                  sa_q, sa_d;
  logic                  sb_q, sb_d;
  logic                  zf_q, zf_d;
  logic [QUOTIENT_W-1:0] quotient_q, quotient_d;
  logic [DIVISOR_W-1:0]  remainder_q, remainder_d;
  logic                  sat_q, sat_d;
  logic                  dz_q, dz_d;

  logic [DIVIDEND_W-1:0] dvd_abs;
  logic [DIVISOR_W-1:0]  dsr_abs;
  logic [DIVISOR_W:0]    shifted;
  logic [DIVISOR_W+1:0]  trial;
  logic [DIVISOR_W-1:0]  rem_signed;

  // Two's-complement magnitude; the most negative value maps to its unsigned magnitude.
  assign dvd_abs = bus.dividend[DIVIDEND_W-1] ? (~bus.dividend + DIVIDEND_W'(1)) : bus.dividend;
  assign dsr_abs = bus.divisor[DIVISOR_W-1]   ? (~bus.divisor  + DIVISOR_W'(1))  : bus.divisor;

  assign shifted    = {rem_q[DIVISOR_W-1:0], dvd_q[DIVIDEND_W-1]};
  assign trial      = {1'b0, shifted} - {2'b00, dsr_q};
  assign rem_signed = sa_q ? (~rem_q[DIVISOR_W-1:0] + DIVISOR_W'(1)) : rem_q[DIVISOR_W-1:0];

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;
  assign bus.sat       = sat_q;
  assign bus.dz        = dz_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dvd_d       = dvd_q;
    quo_d       = quo_q;
    dsr_d       = dsr_q;
    rem_d       = rem_q;
    sa_d        = sa_q;
    sb_d        = sb_q;
    zf_d        = zf_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    sat_d       = sat_q;
    dz_d        = dz_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          dvd_d   = dvd_abs;
          dsr_d   = dsr_abs;
          sa_d    = bus.dividend[DIVIDEND_W-1];
          sb_d    = bus.divisor[DIVISOR_W-1];
          zf_d    = (bus.divisor == '0);
          rem_d   = '0;
          quo_d   = '0;
          cnt_d   = CNT_W'(DIVIDEND_W-1);
          state_d = CALC;
        end
      end

      CALC: begin
        dvd_d = {dvd_q[DIVIDEND_W-2:0], 1'b0};
        quo_d = {quo_q[DIVIDEND_W-2:0], ~trial[DIVISOR_W+1]};
        rem_d = trial[DIVISOR_W+1] ? shifted : trial[DIVISOR_W:0];
        if (cnt_q == '0) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      FIX: begin
        dz_d        = zf_q;
        remainder_d = rem_signed;
        sat_d       = 1'b0;
        quotient_d  = quo_q[QUOTIENT_W-1:0];
        // Divide-by-zero wins over both clamps so the flag is unambiguous.
        if (zf_q) begin
          quotient_d  = QMAX[QUOTIENT_W-1:0];
          remainder_d = '0;
        end else if ((sa_q ^ sb_q) && (quo_q != '0)) begin
          quotient_d = '0;
          sat_d      = 1'b1;
        end else if (quo_q > QMAX) begin
          quotient_d = QMAX[QUOTIENT_W-1:0];
          sat_d      = 1'b1;
        end
        state_d = DONE;
      end

      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dvd_q       <= '0;
      quo_q       <= '0;
      dsr_q       <= '0;
      rem_q       <= '0;
      sa_q        <= 1'b0;
      sb_q        <= 1'b0;
      zf_q        <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      sat_q       <= 1'b0;
      dz_q        <= 1'b0;
    end else if (ce) begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dvd_q       <= dvd_d;
      quo_q       <= quo_d;
      dsr_q       <= dsr_d;
      rem_q       <= rem_d;
      sa_q        <= sa_d;
      sb_q        <= sb_d;
      zf_q        <= zf_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      sat_q       <= sat_d;
      dz_q        <= dz_d;
    end
  end

endmodule

// File: tb/tb_pp_pipeline_accel_div_seq_21s_9s_12u.sv
// Directed bench for the sequential 21s/9s divider: vector table plus handshake, ce and reset sequences.
module tb_pp_pipeline_accel_div_seq_21s_9s_12u;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic ce = 1'b1;
  always #5 clk = ~clk;

  pp_pipeline_accel_div_seq_21s_9s_12u_if bus ();

  pp_pipeline_accel_div_seq_21s_9s_12u dut (
    .clk     (clk),
    .reset_n (reset_n),
    .ce      (ce),
    .bus     (bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int dvd;
    int dsr;
    int q;
    int r;
    bit sat;
    bit dz;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_div(input string nm, input int dvd, input int dsr, input int q, input int r,
                         input bit s, input bit z, input int gap_at, input int gap_len);
    int n;
    logic [8:0] er;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      tick();
      n++;
    end
    chk({nm, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.dividend = 21'(dvd);
    bus.divisor  = 9'(dsr);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 100) begin
      ce = (n >= gap_at && n < gap_at + gap_len) ? 1'b0 : 1'b1;
      tick();
      n++;
    end
    ce = 1'b1;
    chk({nm, "_latency"}, 32'(n), 32'(22 + gap_len));
    er = 9'(r);
    chk({nm, "_quotient"}, 32'(bus.quotient), 32'(q));
    chk({nm, "_remainder"}, 32'(bus.remainder), 32'(er));
    chk({nm, "_sat"}, 32'(bus.sat), 32'(s));
    chk({nm, "_dz"}, 32'(bus.dz), 32'(z));
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk({nm, "_out_valid_clr"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    int av[3];
    int bv[4];
    int n;
    int nacc;
    int t0;
    int t1;
    bit seen;
    bit stable;

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;

    vecs.push_back('{-7000,    -7,   1000, 0,  1'b0, 1'b0});
    vecs.push_back('{7003,     7,    1000, 3,  1'b0, 1'b0});
    vecs.push_back('{-7003,    7,    0,    -3, 1'b1, 1'b0});
    vecs.push_back('{1048575,  1,    4095, 0,  1'b1, 1'b0});
    vecs.push_back('{-1048576, -256, 4095, 0,  1'b1, 1'b0});
    vecs.push_back('{1048575,  255,  4095, 15, 1'b1, 1'b0});
    vecs.push_back('{12345,    0,    4095, 0,  1'b0, 1'b1});
    vecs.push_back('{7,        2,    3,    1,  1'b0, 1'b0});
    vecs.push_back('{-8,       -3,   2,    -2, 1'b0, 1'b0});
    vecs.push_back('{7,        -2,   0,    1,  1'b1, 1'b0});
    av = '{0, 1, 4095};
    bv = '{-256, -1, 1, 255};
    foreach (av[i]) begin
      foreach (bv[j]) begin
        vecs.push_back('{av[i] * bv[j], bv[j], av[i], 0, 1'b0, 1'b0});
      end
    end

    // Reset and idle state
    repeat (3) tick();
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    reset_n = 1'b1;
    tick();
    chk("idle_in_ready", 32'(bus.in_ready), 32'd1);
    chk("idle_out_valid", 32'(bus.out_valid), 32'd0);
    chk("idle_quotient", 32'(bus.quotient), 32'd0);
    chk("idle_remainder", 32'(bus.remainder), 32'd0);
    chk("idle_sat", 32'(bus.sat), 32'd0);
    chk("idle_dz", 32'(bus.dz), 32'd0);

    for (int k = 0; k < vecs.size(); k++) begin
      run_div($sformatf("vec%0d", k), vecs[k].dvd, vecs[k].dsr, vecs[k].q, vecs[k].r,
              vecs[k].sat, vecs[k].dz, 0, 0);
    end

    // ce held low for 5 cycles mid-CALC
    run_div("ce_gap", 7003, 7, 1000, 3, 1'b0, 1'b0, 8, 5);

    // Output stall with a new request presented during DONE
    bus.dividend = 21'(7003);
    bus.divisor  = 9'(7);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 100) begin
      tick();
      n++;
    end
    chk("stall_latency", 32'(n), 32'd22);
    bus.dividend = 21'(500);
    bus.divisor  = 9'(5);
    bus.in_valid = 1'b1;
    stable = 1'b1;
    repeat (10) begin
      tick();
      if (bus.quotient !== 12'd1000 || bus.remainder !== 9'd3 || bus.out_valid !== 1'b1
          || bus.in_ready !== 1'b0) stable = 1'b0;
    end
    chk("stall_stable", 32'(stable), 32'd1);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("stall_release_idle", 32'(bus.in_ready), 32'd1);

    // Back-to-back issue with out_ready held high
    bus.dividend  = 21'(-7000);
    bus.divisor   = 9'(-7);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    nacc = 0;
    t0 = 0;
    t1 = 0;
    n = 0;
    while (nacc < 2 && n < 200) begin
      if (bus.in_ready) begin
        if (nacc == 0) t0 = cyc;
        else t1 = cyc;
        nacc++;
      end
      if (bus.out_valid && bus.quotient !== 12'd1000) begin
        chk("b2b_quotient", 32'(bus.quotient), 32'd1000);
      end
      tick();
      n++;
    end
    bus.in_valid = 1'b0;
    chk("b2b_accepts", 32'(nacc), 32'd2);
    chk("b2b_interval", 32'(t1 - t0), 32'd24);
    repeat (30) tick();
    bus.out_ready = 1'b0;

    // Reset during CALC abandons the operation
    bus.dividend = 21'(7003);
    bus.divisor  = 9'(7);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (10) tick();
    chk("midrst_busy", 32'(bus.in_ready), 32'd0);
    reset_n = 1'b0;
    #1;
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    tick();
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (30) begin
      tick();
      if (bus.out_valid) seen = 1'b1;
    end
    chk("midrst_no_out", 32'(seen), 32'd0);
    chk("midrst_idle", 32'(bus.in_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pp_pipeline_accel_div_seq_21s_9s_12u.md
Name: pp_pipeline_accel_div_seq_21s_9s_12u

Overview:
- Sequential radix-2 divider: the inverse of the 12-bit-unsigned by 9-bit-signed to 21-bit-signed product multiplier in the pp_pipeline_accel datapath.
- Takes a 21-bit signed dividend and a 9-bit signed coefficient, and recovers the 12-bit unsigned operand plus a remainder.
- Used in the normalisation/de-scaling stage of the pre-processing pipeline.
- Valid/ready handshake on input and output; one division in flight at a time.

Parameters:
- DIVIDEND_W, 21, signed dividend width.
- DIVISOR_W, 9, signed divisor width.
- QUOTIENT_W, 12, unsigned saturated quotient width.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- ce  in  1  clock enable; when low, all state, counters and outputs hold.
- in_valid  in  1  dividend/divisor valid.
- in_ready  out  1  block can accept an operand pair.
- dividend  in  DIVIDEND_W  signed dividend.
- divisor  in  DIVISOR_W  signed divisor.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- quotient  out  QUOTIENT_W  unsigned saturated quotient.
- remainder  out  DIVISOR_W  signed remainder; carries the sign of the dividend.
- sat  out  1  quotient was clamped.
- dz  out  1  divisor was zero.

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low. Assertion forces state=IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0, sat=0, dz=0, iteration counter=0. Reset mid-division abandons the operation with no output.
- All register updates are qualified by ce. in_ready and out_valid are decoded from state, so they hold while ce=0.
- FSM states: IDLE, CALC, FIX, DONE.
  - IDLE: in_ready=1. On ce & in_valid (edge E0), latch |dividend| as DIVIDEND_W-bit unsigned (so -2^20 gives 2^20), |divisor| as DIVISOR_W-bit unsigned, both sign bits, and the dz flag. Clear the partial remainder. Set count=DIVIDEND_W-1. Go to CALC.
  - CALC: one restoring step per enabled cycle. Shift the remainder left, bringing in the dividend MSB. Trial-subtract |divisor|. If the result is non-negative, keep it and set the quotient bit to 1; otherwise restore and set 0. When count=0, go to FIX; otherwise decrement count. Exactly DIVIDEND_W cycles (edges E1..E21).
  - FIX (edge E22): apply signs. Quotient sign is the XOR of the operand signs; remainder sign is the dividend sign. Truncate toward zero. Saturate:
    - negative non-zero quotient gives 0, sat=1.
    - magnitude > 2^QUOTIENT_W-1 gives 4095, sat=1.
    - dz=1 forces quotient=4095, remainder=0, sat=0 (same latency, CALC still runs).
    - Register the outputs, set out_valid=1, go to DONE.
  - DONE: outputs stable while out_valid=1 and out_ready=0. On ce & out_ready, out_valid=0 and go to IDLE. in_ready stays 0 in DONE, so there is no same-cycle re-accept.
- Latency: out_valid is visible in the cycle after E22, i.e. 22 enabled cycles after acceptance. Minimum issue interval is 24 enabled cycles.
- in_valid is ignored outside IDLE. Operands are sampled only at acceptance, so input changes during CALC have no effect.
- Exact inverse property: for every a in [0,4095] and b≠0 in [-256,255], dividing the product a*b by b gives quotient=a, remainder=0, sat=0.
- Internal widths: partial remainder DIVISOR_W+1 bits unsigned; quotient shift register DIVIDEND_W bits. Saturation compares the full DIVIDEND_W-bit magnitude.

Test Plan:
- Reset/idle: hold reset_n=0 for 3 cycles, release. Expect in_ready=1, out_valid=0, all outputs 0. Assert reset_n=0 at CALC cycle 10: next cycle in_ready=1 and no out_valid follows.
- Exact inverse: dividend=-7000, divisor=-7. Expect quotient=1000, remainder=0, sat=0, dz=0, with out_valid exactly 22 cycles after acceptance. Sweep a∈{0,1,4095} × b∈{-256,-1,1,255} with dividend=a*b: all give quotient=a, remainder=0.
- Remainder/sign: 7003/7 gives quotient=1000, remainder=3. -7003/7 gives quotient=0, sat=1, remainder=-3.
- Saturation/extremes: 1048575/1 gives quotient=4095, sat=1. -1048576/-256 gives quotient=4095, sat=1 (magnitude 4096). 1048575/255 gives 4095 (4112 clamped), sat=1.
- Divide-by-zero: 12345/0 gives dz=1, quotient=4095, remainder=0, sat=0, same 22-cycle latency.
- Handshake/ce: hold out_ready=0 for 10 cycles and check outputs stable with in_ready=0 and a new in_valid ignored. Toggle ce low for 5 cycles mid-CALC: latency grows by exactly 5 and the result is unchanged. Run back-to-back ops with out_ready=1: second acceptance occurs 24 cycles after the first.
